// File: rtl/spi_target_pkg.sv
// Shared types and constants for the SPI target register-bus bridge.
package spi_target_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    WDATA,
    RDATA,
    IGNORE
  } state_t;

  localparam logic [7:0] CMD_WRITE_DEF = 8'h02;
  localparam logic [7:0] CMD_READ_DEF  = 8'h0B;
  localparam logic [7:0] RD_FILL       = 8'hFF;

endpackage

// File: rtl/spi_target_sync.sv
// Synchronizes the asynchronous SPI pins into clk and derives SCK/CS edge pulses.
module spi_target_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic spi_cs_n,
  input  logic spi_sck,
  input  logic spi_mosi,
  output logic cs_n_s,
  output logic mosi_s,
  output logic sck_rise,
  output logic sck_fall,
  output logic cs_fall
);

  logic [SYNC_STAGES-1:0] cs_pipe;
  logic [SYNC_STAGES-1:0] sck_pipe;
  logic [SYNC_STAGES-1:0] mosi_pipe;
  logic                   sck_prev;
  logic                   cs_prev;

  // Reset state mimics an idle bus: CS deasserted, SCK low.
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_pipe   <= '1;
      sck_pipe  <= '0;
      mosi_pipe <= '0;
      sck_prev  <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      cs_pipe   <= {cs_pipe[SYNC_STAGES-2:0], spi_cs_n};
      sck_pipe  <= {sck_pipe[SYNC_STAGES-2:0], spi_sck};
      mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], spi_mosi};
      sck_prev  <= sck_pipe[SYNC_STAGES-1];
      cs_prev   <= cs_pipe[SYNC_STAGES-1];
    end
  end

  assign cs_n_s   = cs_pipe[SYNC_STAGES-1];
  assign mosi_s   = mosi_pipe[SYNC_STAGES-1];
  assign sck_rise = sck_pipe[SYNC_STAGES-1] & ~sck_prev;
  assign sck_fall = ~sck_pipe[SYNC_STAGES-1] & sck_prev;
  assign cs_fall  = ~cs_pipe[SYNC_STAGES-1] & cs_prev;

endmodule

// File: rtl/spi_target_regif.sv
// SPI mode-0 target bridging flash-style frames (cmd, addr, data...) onto an 8-bit register bus.
//   state  | meaning
//   IDLE   | CS high, waiting for frame
//   CMD    | receiving command byte
//   ADDR   | receiving address bytes, MSB first
//   DUMMY  | read turnaround byte, first read in flight
//   WDATA  | each byte written at m_addr, then address increments
//   RDATA  | bytes shifted out on MISO with next-address prefetch
//   IGNORE | unknown command, idle until CS high
module spi_target_regif
  import spi_target_pkg::*;
#(
  parameter int          ADDR_BYTES  = 1,
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  CMD_WRITE   = CMD_WRITE_DEF,
  parameter logic [7:0]  CMD_READ    = CMD_READ_DEF,
  localparam int         ADDR_BITS   = 8 * ADDR_BYTES
) (
  input  logic                 reset,
  input  logic                 clk,
  input  logic                 spi_cs_n,
  input  logic                 spi_sck,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  output logic                 spi_miso_oe,
  output logic [ADDR_BITS-1:0] m_addr,
  output logic [7:0]           m_wdata,
  output logic                 m_wen,
  output logic                 m_ren,
  input  logic [7:0]           s_rdata,
  input  logic                 s_rvalid,
  output logic                 busy,
  output logic                 err_rd
);

  state_t               state;
  state_t               state_nx;
  logic                 cs_n_s;
  logic                 mosi_s;
  logic                 sck_rise;
  logic                 sck_fall;
  logic                 cs_fall;
  logic [2:0]           bit_cnt;
  logic [7:0]           rx;
  logic                 byte_done;
  logic                 is_rd;
  logic [1:0]           addr_cnt;
  logic                 addr_last;
  logic [ADDR_BITS-1:0] addr_next;
  logic [7:0]           tx;
  logic [7:0]           rd_buf;
  logic                 rd_pend;
  logic                 rd_ok;
  logic                 load_pend;
  logic                 wr_inc;
  logic                 pf_pend;

  spi_target_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .reset    (reset),
    .spi_cs_n (spi_cs_n),
    .spi_sck  (spi_sck),
    .spi_mosi (spi_mosi),
    .cs_n_s   (cs_n_s),
    .mosi_s   (mosi_s),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .cs_fall  (cs_fall)
  );

  assign addr_last = (addr_cnt == 2'(ADDR_BYTES - 1));

  generate
    if (ADDR_BYTES == 1) begin : g_addr1
      assign addr_next = rx;
    end else begin : g_addrn
      assign addr_next = {m_addr[ADDR_BITS-9:0], rx};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (cs_n_s) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:  state_nx = CMD;
        CMD:   if (byte_done) state_nx = (rx == CMD_WRITE || rx == CMD_READ) ? ADDR : IGNORE;
        ADDR:  if (byte_done && addr_last) state_nx = is_rd ? DUMMY : WDATA;
        DUMMY: if (byte_done) state_nx = RDATA;
        default: state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt   <= '0;
      rx        <= '0;
      byte_done <= 1'b0;
      is_rd     <= 1'b0;
      addr_cnt  <= '0;
      tx        <= '1;
      rd_buf    <= '0;
      rd_pend   <= 1'b0;
      rd_ok     <= 1'b0;
      load_pend <= 1'b0;
      wr_inc    <= 1'b0;
      pf_pend   <= 1'b0;
      err_rd    <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      m_wen     <= 1'b0;
      m_ren     <= 1'b0;
    end else begin
      m_wen     <= 1'b0;
      m_ren     <= 1'b0;
      wr_inc    <= 1'b0;
      pf_pend   <= 1'b0;
      byte_done <= !cs_n_s && sck_rise && (bit_cnt == 3'd7);

      if (cs_n_s) begin
        bit_cnt <= '0;
      end else if (sck_rise) begin
        bit_cnt <= bit_cnt + 3'd1;
        rx      <= {rx[6:0], mosi_s};
      end

      if (cs_fall) err_rd <= 1'b0;
      if (state == IDLE) addr_cnt <= '0;

      if (byte_done) begin
        case (state)
          CMD: is_rd <= (rx == CMD_READ);
          ADDR: begin
            addr_cnt <= addr_cnt + 2'd1;
            m_addr   <= addr_next;
            if (addr_last && is_rd) begin
              m_ren   <= 1'b1;
              rd_pend <= 1'b1;
              rd_ok   <= 1'b0;
            end
          end
          WDATA: begin
            m_wdata <= rx;
            m_wen   <= 1'b1;
            wr_inc  <= 1'b1;
          end
          default: ;
        endcase
      end

      if (wr_inc) m_addr <= m_addr + 1'b1;

      if (cs_n_s) begin
        rd_pend   <= 1'b0;
        rd_ok     <= 1'b0;
        load_pend <= 1'b0;
        tx        <= '1;
      end else begin
        if (byte_done && (state == DUMMY || state == RDATA)) load_pend <= 1'b1;
        if (rd_pend && s_rvalid) begin
          rd_buf  <= s_rdata;
          rd_ok   <= 1'b1;
          rd_pend <= 1'b0;
        end
        // A load abandons any read still in flight; late data would belong to the wrong address.
        if (sck_fall && state == RDATA) begin
          if (load_pend) begin
            tx        <= rd_ok ? rd_buf : RD_FILL;
            if (!rd_ok) err_rd <= 1'b1;
            rd_ok     <= 1'b0;
            rd_pend   <= 1'b0;
            load_pend <= 1'b0;
            pf_pend   <= 1'b1;
          end else begin
            tx <= {tx[6:0], 1'b1};
          end
        end
        if (pf_pend) begin
          m_addr  <= m_addr + 1'b1;
          m_ren   <= 1'b1;
          rd_pend <= 1'b1;
        end
      end
    end
  end

  assign busy        = ~cs_n_s;
  assign spi_miso_oe = busy & (state == DUMMY || state == RDATA);
  assign spi_miso    = spi_miso_oe ? tx[7] : 1'b1;

endmodule

// File: tb/tb_spi_target_regif.sv
// Scoreboard bench: host BFM plus register model feed expectation queues; a monitor checks strobes and MISO.
module tb_spi_target_regif;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       spi_cs_n = 1'b1;
  logic       spi_sck = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic [7:0] m_addr;
  logic [7:0] m_wdata;
  logic       m_wen;
  logic       m_ren;
  logic [7:0] s_rdata = 8'h00;
  logic       s_rvalid = 1'b0;
  logic       busy;
  logic       err_rd;

  always #5 clk = ~clk;

  spi_target_regif dut (
    .reset       (reset),
    .clk         (clk),
    .spi_cs_n    (spi_cs_n),
    .spi_sck     (spi_sck),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .m_addr      (m_addr),
    .m_wdata     (m_wdata),
    .m_wen       (m_wen),
    .m_ren       (m_ren),
    .s_rdata     (s_rdata),
    .s_rvalid    (s_rvalid),
    .busy        (busy),
    .err_rd      (err_rd)
  );

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  int         n_checks = 0;
  int         n_fail = 0;
  wr_t        exp_wr[$];
  logic [7:0] exp_rd[$];
  logic [7:0] exp_rx[$];
  logic [7:0] obs_rx[$];
  bit         withhold = 1'b0;
  bit         oe_seen = 1'b0;
  logic [7:0] frame_tx[16];

  // Register contents seen by the bridge: chosen so address 0x20 reads 0x30.
  function automatic logic [7:0] reg_val(input logic [7:0] a);
    return 8'(a + 8'h10);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Register responder: answers each read three clocks later unless withheld.
  initial begin
    logic       v1, v2;
    logic [7:0] d1, d2;
    v1 = 0; v2 = 0; d1 = 0; d2 = 0;
    forever begin
      @(negedge clk);
      s_rvalid = v2;
      s_rdata  = d2;
      v2 = v1;
      d2 = d1;
      v1 = m_ren && !withhold;
      d1 = reg_val(m_addr);
    end
  end

  // Monitor: pops expectations whenever the DUT presents a strobe or the host completes a MISO byte.
  initial begin
    wr_t        w;
    logic [7:0] r;
    forever begin
      @(negedge clk);
      if (spi_miso_oe) oe_seen = 1'b1;
      if (m_wen) begin
        check("wen/ren overlap", m_ren, 0);
        n_checks++;
        if (exp_wr.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected m_wen: got addr %0h data %0h expected no write", m_addr, m_wdata);
        end else begin
          w = exp_wr.pop_front();
          check("write addr", m_addr, w.a);
          check("write data", m_wdata, w.d);
        end
      end
      if (m_ren) begin
        n_checks++;
        if (exp_rd.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected m_ren: got addr %0h expected no read", m_addr);
        end else begin
          r = exp_rd.pop_front();
          check("read addr", m_addr, r);
        end
      end
      if (obs_rx.size() > 0) begin
        r = obs_rx.pop_front();
        n_checks++;
        if (exp_rx.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected miso byte: got %0h expected none", r);
        end else begin
          check("miso byte", r, exp_rx.pop_front());
        end
      end
    end
  end

  // Host BFM: mode 0, SCK = clk/10. CS rises together with the final SCK fall.
  task automatic spi_frame(input int total_bits, input int rx_skip, input bit is_read);
    logic [7:0] cur;
    cur = 8'h00;
    @(negedge clk);
    spi_cs_n = 1'b0;
    #50;
    for (int i = 0; i < total_bits; i++) begin
      spi_mosi = frame_tx[i / 8][7 - (i % 8)];
      #50;
      spi_sck = 1'b1;
      cur = {cur[6:0], spi_miso};
      if ((i % 8) == 7 && is_read && (i / 8) >= rx_skip) obs_rx.push_back(cur);
      #50;
      spi_sck = 1'b0;
      if (i == total_bits - 1) spi_cs_n = 1'b1;
    end
    spi_cs_n = 1'b1;
    #300;
  endtask

  task automatic frame_done(input string name, input bit exp_oe);
    repeat (3) @(negedge clk);
    check({name, " writes drained"}, exp_wr.size(), 0);
    check({name, " reads drained"}, exp_rd.size(), 0);
    check({name, " miso drained"}, exp_rx.size(), 0);
    check({name, " miso_oe seen"}, oe_seen, exp_oe);
    check({name, " busy idle"}, busy, 0);
    exp_wr.delete();
    exp_rd.delete();
    exp_rx.delete();
    oe_seen = 1'b0;
  endtask

  // Builds expectations from the frame bytes, then plays the frame.
  task automatic run_frame(input string name, input int nbytes, input int cut_bits);
    int         bits, nfull, ndata;
    logic [7:0] cmd, addr;
    bits  = (cut_bits >= 0) ? cut_bits : nbytes * 8;
    nfull = bits / 8;
    cmd   = frame_tx[0];
    addr  = frame_tx[1];
    if (cmd == 8'h02) begin
      for (int i = 0; i < nfull - 2; i++) exp_wr.push_back({8'(addr + i), frame_tx[2 + i]});
    end else if (cmd == 8'h0B) begin
      ndata = nfull - 3;
      for (int i = 0; i <= ndata; i++) exp_rd.push_back(8'(addr + i));
      for (int i = 0; i < ndata; i++)
        exp_rx.push_back(withhold ? 8'hFF : reg_val(8'(addr + i)));
    end
    spi_frame(bits, 3, cmd == 8'h0B);
    frame_done(name, cmd == 8'h0B);
  endtask

  task automatic check_reset_vals(input string name);
    check({name, " miso"}, spi_miso, 1);
    check({name, " miso_oe"}, spi_miso_oe, 0);
    check({name, " m_addr"}, m_addr, 0);
    check({name, " m_wdata"}, m_wdata, 0);
    check({name, " m_wen"}, m_wen, 0);
    check({name, " m_ren"}, m_ren, 0);
    check({name, " busy"}, busy, 0);
    check({name, " err_rd"}, err_rd, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, n, k;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    repeat (5) @(negedge clk);

    frame_tx[0] = 8'h02; frame_tx[1] = 8'h10; frame_tx[2] = 8'hA5; frame_tx[3] = 8'h5A;
    run_frame("write", 4, -1);

    frame_tx[0] = 8'h0B; frame_tx[1] = 8'h20; frame_tx[2] = 8'h00;
    frame_tx[3] = 8'h00; frame_tx[4] = 8'h00;
    run_frame("read", 5, -1);
    check("err_rd after good read", err_rd, 0);

    withhold = 1'b1;
    frame_tx[0] = 8'h0B; frame_tx[1] = 8'h40;
    run_frame("withheld read", 5, -1);
    withhold = 1'b0;
    check("err_rd set", err_rd, 1);
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (10) @(negedge clk);
    check("err_rd cleared by cs fall", err_rd, 0);
    check("busy during cs low", busy, 1);
    spi_cs_n = 1'b1;
    #300;
    frame_done("cs pulse", 0);

    frame_tx[0] = 8'h02; frame_tx[1] = 8'h10; frame_tx[2] = 8'hC3;
    run_frame("aborted write", 3, 21);
    frame_tx[0] = 8'h02; frame_tx[1] = 8'h00; frame_tx[2] = 8'h11;
    run_frame("write after abort", 3, -1);

    frame_tx[0] = 8'h02; frame_tx[1] = 8'hFF; frame_tx[2] = 8'h01; frame_tx[3] = 8'h02;
    run_frame("addr wrap", 4, -1);

    frame_tx[0] = 8'h9F; frame_tx[1] = 8'h12; frame_tx[2] = 8'h34; frame_tx[3] = 8'h56;
    run_frame("unknown cmd", 4, -1);

    for (int f = 0; f < 30; f++) begin
      kind = $urandom_range(0, 2);
      n    = $urandom_range(1, 3);
      for (int j = 0; j < 16; j++) frame_tx[j] = 8'($urandom);
      if (kind == 0) begin
        frame_tx[0] = 8'h02;
        run_frame("rand write", 2 + n, -1);
      end else if (kind == 1) begin
        frame_tx[0] = 8'h0B;
        withhold = ($urandom_range(0, 4) == 0);
        run_frame("rand read", 3 + n, -1);
        withhold = 1'b0;
      end else begin
        while (frame_tx[0] == 8'h02 || frame_tx[0] == 8'h0B) frame_tx[0] = 8'($urandom);
        run_frame("rand unknown", 2 + n, -1);
      end
    end

    frame_tx[0] = 8'h0B; frame_tx[1] = 8'h60; frame_tx[2] = 8'h00;
    frame_tx[3] = 8'h00; frame_tx[4] = 8'h00;
    exp_rd.push_back(8'h60);
    fork
      spi_frame(40, 3, 1'b0);
      begin
        k = 0;
        while (!spi_miso_oe && k < 400) begin
          @(negedge clk);
          k++;
        end
        check("oe before mid-read reset", spi_miso_oe, 1);
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("mid-read reset");
      end
    join
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #200;
    frame_done("mid-read reset", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
